// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial subtractor.
//
// Contents:
//   state_e    - serial subtractor FSM state (idle / run / done)
//   DefaultW   - default operand width
//   DefaultCntW- bit-counter width for the default operand width
//   cnt_width  - counter width for an arbitrary operand width
//   ref_sub    - reference {borrow_out, difference} of (a - b - bin) mod 2^w
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultW    = 8;
    localparam int unsigned DefaultCntW = $clog2(DefaultW);

    // Width of a counter that must reach w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Returns {bout, d} packed as bit 32 and bits [31:0]; d is masked to w bits.
    function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        bin,
                                            input int unsigned w);
        logic [31:0] mask;
        logic [32:0] wide;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        // Operands are below 2^32, so a negative result always sets bit 32.
        wide = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
        return {wide[32], wide[31:0] & mask};
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin.
//
// Ports:
//   a_i    - minuend bit
//   b_i    - subtrahend bit
//   bin_i  - borrow in
//   d_o    - difference bit
//   bout_o - borrow out
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when b exceeds a, or when a == b and a borrow is already pending.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: D = (A - B - bin) mod 2^W, LSB first, one bit per clock.
// A start accepted in idle or done loads the operands; W cycles later a one-cycle done
// pulse presents the difference and final borrow, which hold until the next accept.
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add ovf_o, the two's-complement
// overflow (borrow into MSB xor borrow out of MSB), registered alongside d_o.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset
//   start_i - operation request, sampled only in idle or done
//   a_i     - minuend, captured on accept
//   b_i     - subtrahend, captured on accept
//   bin_i   - borrow in, captured on accept
//   busy_o  - high while bits are being resolved
//   done_o  - one-cycle result-valid pulse
//   d_o     - difference
//   bout_o  - final borrow out
//   ovf_o   - signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] d_o,
    output logic         bout_o
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    localparam int unsigned CntW = cnt_width(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    state_e state_q, state_d;

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    // Holds the W-1 bits resolved so far; the final bit joins it on the last edge.
    logic [W-2:0]    acc_q, acc_d;
    logic            br_q, br_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    res_q, res_d;
    logic            bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic         cell_d;
    logic         cell_bout;
    logic [W-1:0] shifted;
    logic         accept;

    full_subtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // New bit enters from the MSB side so bit 0 ends up in position 0 after W shifts.
    assign shifted = {cell_d, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d   = ovf_q;
`endif
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    accept = 1'b1;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = shifted[W-1:1];
                br_d  = cell_bout;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    res_d   = shifted;
                    bout_d  = cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // br_q is the borrow into the MSB on this last step.
                    ovf_d   = br_q ^ cell_bout;
`endif
                end
            end
            StDone: begin
                if (start_i) begin
                    accept = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d = StRun;
            a_d     = a_i;
            b_d     = b_i;
            br_d    = bin_i;
            cnt_d   = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign d_o    = res_q;
    assign bout_o = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8): table of directed vectors, plus
// hand-written reset, back-to-back, mid-operation reset and random reference checks.
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.W(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .d_o     (d),
        .bout_o  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf_o   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from idle; checks busy/done timing and returns the result.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic bi_n,
                          output logic [7:0] dr, output logic br, output logic ovr);
        int bad;
        a     = ai;
        b     = bi;
        bin   = bi_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        bad   = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            // Requests during run must be ignored.
            if (i < int'(W) - 1) start = i[0];
            // Operands changing mid-run must not matter.
            a = ~ai;
            b = ~bi;
            tick();
        end
        start = 1'b0;
        check("run_busy_window", bad, 0);
        check("done_at_latency", {30'd0, busy, done}, 32'd1);
        dr  = d;
        br  = bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovr = ovf;
`else
        ovr = 1'b0;
`endif
        tick();
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("result_held", {23'd0, bout, d}, {23'd0, br, dr});
    endtask

    initial begin
        logic [7:0]  dr;
        logic        br;
        logic        ovr;
        logic [32:0] ref_v;
        int          bad;
        int          ndone;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[8] = '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'h3C, 8'hC3, 1'b1, 8'h78, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        check("reset_outputs", {22'd0, busy, done, bout, d}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_after_reset", {22'd0, busy, done, bout, d}, 32'd0);
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, dr, br, ovr);
            check($sformatf("vec%0d_d", i), {24'd0, dr}, {24'd0, vecs[i].d});
            check($sformatf("vec%0d_bout", i), {31'd0, br}, {31'd0, vecs[i].bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'd0, ovr}, {31'd0, vecs[i].ovf});
`endif
        end

        // Start held high: re-accept in the done cycle, done every W+1 cycles.
        a     = 8'h10;
        b     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        bad   = 0;
        ndone = 0;
        for (int c = 1; c <= 35; c++) begin
            tick();
            if (done !== ((c % 9) == 8)) bad++;
            if (done === 1'b1) begin
                ndone++;
                if (d !== 8'h0F || bout !== 1'b0) bad++;
            end
            if (c >= 27) start = 1'b0;
        end
        check("b2b_timing_and_value", bad, 0);
        check("b2b_done_count", ndone, 4);
        tick();
        check("b2b_back_to_idle", {30'd0, busy, done}, 32'd0);

        // Reset during the 4th run cycle abandons the operation.
        a     = 8'hA5;
        b     = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", {22'd0, busy, done, bout, d}, 32'd0);
        bad = 0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check("midrst_no_done", bad, 0);
        run_op(8'hA5, 8'h5A, 1'b0, dr, br, ovr);
        check("midrst_fresh_d", {24'd0, dr}, 32'h4B);
        check("midrst_fresh_bout", {31'd0, br}, 32'd0);

        // Random operands against the package reference function.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            rc    = 1'($urandom_range(0, 1));
            ref_v = ref_sub({24'd0, ra}, {24'd0, rb}, rc, W);
            run_op(ra, rb, rc, dr, br, ovr);
            check($sformatf("rand%0d_d", i), {24'd0, dr}, ref_v[31:0]);
            check($sformatf("rand%0d_bout", i), {31'd0, br}, {31'd0, ref_v[32]});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check($sformatf("rand%0d_ovf", i), {31'd0, ovr},
                  {31'd0, (ra[7] ^ rb[7]) & (ra[7] ^ ref_v[7])});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor: D = A - B - bin. It is the subtraction counterpart of the team's combinational full adder. The block loads two operands on a start handshake and resolves one bit per clock, LSB first, through a full-subtractor bit cell and a borrow flip-flop. It then presents the difference and borrow-out with a one-cycle done pulse. It is an area-cheap arithmetic unit for the datapath library, and chains via bin/bout.

Parameters:
W, 8, operand/result width in bits (legal: 2..32)

Ports:
clk    input   1   single clock, rising edge
rst    input   1   synchronous reset, active-high
start  input   1   request; sampled only in IDLE or DONE
A      input   W   minuend, captured on accepted start
B      input   W   subtrahend, captured on accepted start
bin    input   1   borrow-in, captured on accepted start
busy   output  1   high while in RUN
done   output  1   one-cycle pulse when result valid
D      output  W   difference, valid from done, held until next accept
bout   output  1   final borrow-out, same validity as D

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. rst at a rising edge forces the following, overriding start:
  - state=IDLE, busy=0, done=0, D=0, bout=0
  - shift registers, bit counter and borrow FF cleared
- Mid-operation reset: the in-flight operation is abandoned, no done is issued, and outputs read 0 after the edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture A, B into shift regs, bin into borrow FF; cnt=0; go to RUN. Otherwise stay.
  - RUN: each edge computes the bit cell on (a0, b0, borrow):
    - d = a0 ^ b0 ^ br
    - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into D from the MSB side; A/B shift right; cnt++.
    - When cnt==W-1 on this edge, go to DONE.
  - DONE: done=1 for exactly this one cycle; bout = borrow FF.
    - start=1 -> accept a new operation as in IDLE (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+W, so throughput is one operation per W+1 cycles.
- start while busy is ignored: not queued, no error.
- D/bout are not updated during RUN. The internal accumulator is separate, and D/bout load on the RUN->DONE edge.
- Arithmetic: D = (A - B - bin) mod 2^W. bout=1 iff A < B + bin (unsigned).
- Boundaries:
  - A=B with bin=0 -> D=0, bout=0.
  - A=0, B=0, bin=1 -> D=all ones, bout=1.
  - A=0, B=2^W-1, bin=1 -> D=0, bout=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined: adds output port ovf (1 bit). ovf is the two's-complement overflow of the subtraction, computed as the borrow into the MSB XOR the borrow out of the MSB. It is registered with D, has the same validity, and resets to 0.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Decomposition:
- Shared package arith_pkg:
  - state enum type (IDLE/RUN/DONE)
  - localparam for counter width, $clog2(W)
  - function computing the reference difference/borrow, for reuse by the bench
- One sub-module: full_subtractor. It is the combinational bit cell with inputs a, b, bin and outputs d, bout, instantiated once inside the RUN datapath.

Test Plan:
1. rst held 2 cycles then released, start=0 -> busy=0, done=0, D=0x00, bout=0 indefinitely.
2. W=8: A=0x05, B=0x03, bin=0, start one cycle -> busy high 8 cycles; done single pulse exactly 8 edges after accept; D=0x02, bout=0.
3. A=0x00, B=0xFF, bin=1 -> D=0x00, bout=1. Then A=0x00, B=0x00, bin=1 -> D=0xFF, bout=1.
4. start held high continuously with A=0x10, B=0x01 -> second operation accepted in the DONE cycle; done pulses every 9 cycles with D=0x0F each time. start pulses during RUN cause no extra done.
5. rst asserted at the 4th RUN cycle of A=0xA5, B=0x5A -> next cycle state IDLE, busy=0, D=0, no done; a fresh start then yields D=0x4B, bout=0.
6. With SERIAL_SUBTRACTOR_OVF_EN: A=0x80, B=0x01, bin=0 -> D=0x7F, ovf=1, bout=0. A=0x7F, B=0xFF -> D=0x80, ovf=1, bout=1. A=0x03, B=0x01 -> ovf=0.
